// File: rtl/alu_arbiter.sv
// Round-robin front end that shares one combinational ALU between two requesters.
// It holds the ALU inputs for a per-op number of cycles and returns the result over a valid/ready channel.
module alu_arbiter #(
   parameter int unsigned MUL_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        a_valid,
   input  logic        b_valid,
   output logic        a_ready,
   output logic        b_ready,
   input  logic [31:0] a_op1,
   input  logic [31:0] a_op2,
   input  logic [31:0] b_op1,
   input  logic [31:0] b_op2,
   input  logic [3:0]  a_sel,
   input  logic [3:0]  b_sel,
   output logic [31:0] alu_op1,
   output logic [31:0] alu_op2,
   output logic [3:0]  alu_sel,
   input  logic [31:0] alu_out,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic        rsp_zf,
   output logic        rsp_id,
   output logic        rsp_err,
   output logic        busy
);

   localparam logic [3:0] SEL_AND = 4'b0000;
   localparam logic [3:0] SEL_OR  = 4'b0001;
   localparam logic [3:0] SEL_ADD = 4'b0010;
   localparam logic [3:0] SEL_MUL = 4'b0101;
   localparam logic [3:0] SEL_SUB = 4'b0110;
   localparam logic [3:0] SEL_SLT = 4'b0111;
   localparam logic [3:0] MUL_CNT = MUL_CYCLES[3:0];

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t      state;
   logic        last_grant;
   logic [3:0]  cnt;
   logic        accept;
   logic        grant_b;
   logic [31:0] req_op1;
   logic [31:0] req_op2;
   logic [3:0]  req_sel;
   logic        sel_ok;

   // On a tie the port that did not win last time is granted.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      a_ready = 1'b0;
      b_ready = 1'b0;
      if (state == IDLE) begin
         a_ready = a_valid && (!b_valid || last_grant);
         b_ready = b_valid && (!a_valid || !last_grant);
      end
   end

   assign accept  = a_ready || b_ready;
   assign grant_b = b_ready;
   assign req_op1 = grant_b ? b_op1 : a_op1;
   assign req_op2 = grant_b ? b_op2 : a_op2;
   assign req_sel = grant_b ? b_sel : a_sel;

   always_comb begin
      case (req_sel)
         SEL_AND, SEL_OR, SEL_ADD, SEL_SUB, SEL_SLT, SEL_MUL: sel_ok = 1'b1;
         default:                                             sel_ok = 1'b0;
      endcase
   end

   assign rsp_valid = (state == RESP);
   assign busy      = (state != IDLE);

   // NOTE: state is updated with non-blocking assignments only, so every read sees the pre-edge value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         cnt        <= 4'd0;
         alu_op1    <= '0;
         alu_op2    <= '0;
         alu_sel    <= 4'b0000;
         rsp_data   <= '0;
         rsp_zf     <= 1'b0;
         rsp_id     <= 1'b0;
         rsp_err    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  alu_op1    <= req_op1;
                  alu_op2    <= req_op2;
                  alu_sel    <= req_sel;
                  rsp_id     <= grant_b;
                  last_grant <= grant_b;
                  cnt        <= (req_sel == SEL_MUL) ? MUL_CNT : 4'd1;
                  if (sel_ok) begin
                     state <= EXEC;
                  end else begin
                     // Unsupported op skips the ALU entirely.
                     state    <= RESP;
                     rsp_err  <= 1'b1;
                     rsp_data <= '0;
                     rsp_zf   <= 1'b0;
                  end
               end
            end
            EXEC: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) begin
                  rsp_data <= alu_out;
                  rsp_zf   <= (alu_out == '0);
                  rsp_err  <= 1'b0;
                  state    <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational ALU between two requesters: the core datapath (port A) and the auxiliary/coprocessor path (port B). It arbitrates round-robin, latches operands, and drives the ALU for a per-operation number of cycles. It then registers the result and zero flag and returns them on a shared response channel with a valid/ready handshake. It sits between the issue logic and the ALU; the ALU itself stays purely combinational.

## Interface
- MUL_CYCLES, 2: cycles the ALU inputs are held stable for Sel=0101 (multiply); legal range 1..15.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- a_valid, b_valid  in  1  request valid, ports A/B.
- a_ready, b_ready  out  1  request accepted this cycle when valid&ready.
- a_op1, a_op2, b_op1, b_op2  in  32  operands.
- a_sel, b_sel  in  4  ALU op code: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 0101 MUL.
- alu_op1, alu_op2  out  32  to ALU Op1/Op2 (registered).
- alu_sel  out  4  to ALU Sel (registered).
- alu_out  in  32  ALU result.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer accepts response.
- rsp_data  out  32  captured result.
- rsp_zf  out  1  1 when rsp_data==0 and rsp_err==0.
- rsp_id  out  1  0 = port A, 1 = port B.
- rsp_err  out  1  unsupported op code.
- busy  out  1  state != IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: a_ready/b_ready are combinational from the valids and last_grant. At most one is high. Both are 0 outside IDLE.
- Arbitration:
  - Only one valid: that port wins.
  - Both valid: the port not equal to last_grant wins.
  - last_grant updates on every accept.
- Accept (valid&ready in IDLE):
  - Latch op1/op2/sel into alu_op1/alu_op2/alu_sel, and the port into rsp_id.
  - Load exec counter with MUL_CYCLES for 0101, else 1.
- Supported sel: go to EXEC. Unsupported sel (any code outside the list above):
  - Go directly to RESP with rsp_err=1, rsp_data=0, rsp_zf=0.
  - alu_* are still latched but ignored.
- EXEC: counter decrements each cycle. On the cycle the counter equals 1:
  - Capture rsp_data<=alu_out and rsp_zf<=(alu_out==0).
  - Clear rsp_err.
  - Go to RESP.
- Zero flag is recomputed from the captured result; the ALU's own ZF output is not used.
- RESP: rsp_valid=1. rsp_data/rsp_zf/rsp_id/rsp_err are stable until rsp_ready=1, then go to IDLE.
- No new request is accepted in the RESP→IDLE transfer cycle. One transaction is in flight at a time.
- alu_op1/alu_op2/alu_sel hold their last values in IDLE and RESP. They change only on accept.
- Arithmetic is entirely inside the ALU; the controller performs no width changes.

## Timing
- Reset (async assert, sync to clk on release) drives:
  - state=IDLE, last_grant=1 (port A wins the first tie).
  - alu_op1=alu_op2=0, alu_sel=0000.
  - rsp_valid=0, rsp_data=0, rsp_zf=0, rsp_id=0, rsp_err=0, busy=0.
  - Counter=0.
- Latency from accept edge to first rsp_valid cycle:
  - 1+1 = 2 cycles for single-cycle ops.
  - MUL_CYCLES+1 for MUL.
  - 1 for unsupported ops.
- Throughput, with rsp_ready held high: one op per 3 cycles for single-cycle ops (accept, EXEC, RESP).
- Requester may drop valid without handshake; no ready is owed.
- Requester must hold op1/op2/sel stable while valid&!ready.
- Backpressure: rsp_valid holds indefinitely while rsp_ready=0. Requests wait in IDLE-blocked state (ready=0).
- Reset mid-EXEC or mid-RESP aborts the transaction: no response, outputs return to reset values immediately.
- rsp_ready while rsp_valid=0 is ignored.

## Test plan
- A only: ADD 5+7 → a_ready for 1 cycle; 2 cycles later rsp_valid, rsp_data=12, rsp_zf=0, rsp_id=0.
- Tie fairness: A and B both valid continuously, A=SUB 9-9, B=OR 0xF0|0x0F. Grants must go A, B, A, B. A responses have data=0, zf=1; B responses have data=0xFF, zf=0.
- MUL with MUL_CYCLES=3: 6*7 → alu_sel=0101 held 3 cycles, rsp_valid 4 cycles after accept, data=42.
- Unsupported sel=1111 from B → rsp_valid next cycle, rsp_err=1, data=0, zf=0, id=1.
- Backpressure: rsp_ready=0 for 10 cycles with SLT 3<8 → rsp_data=1 stable, a_ready=0 and b_ready=0 throughout; accept resumes after rsp_ready.
- Reset asserted in EXEC of a MUL → all outputs at reset values asynchronously; no rsp_valid after release until a new request.
